// File: rtl/mem_wb_pkg.sv
// Shared types and sizing helpers for the MEM->WB stage register.
package mem_wb_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_t;

    // Payload = {wb_en, mem_r_en, ld_data, alu_res, dest}
    function automatic int unsigned payload_w(input int unsigned data_w,
                                              input int unsigned reg_aw);
        return 2 + 2 * data_w + reg_aw;
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready pipeline register with optional 2-entry skid buffer and flush.
module pipe_skid_reg
    import mem_wb_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 20,
    parameter bit          SKID      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
);

    pipe_state_t          state_q, state_d;
    logic [PAYLOAD_W-1:0] main_q, skid_q;
    logic                 accept, emit;
    logic                 load_main, load_skid, main_from_skid;

    assign out_valid = (state_q != ST_EMPTY);
    // With the skid buffer in_ready is a pure flop decode; without it, WB readiness passes straight through.
    assign in_ready  = SKID ? (state_q != ST_SKID) : (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;
    assign out_data  = main_q;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d   = ST_FULL;
                        load_main = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (accept && !emit && SKID) begin
                        state_d   = ST_SKID;
                        load_skid = 1'b1;
                    end else if (accept) begin
                        load_main = 1'b1;
                    end else if (emit) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (emit) begin
                        state_d        = ST_FULL;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main) main_q <= main_from_skid ? skid_q : in_data;
            if (load_skid) skid_q <= in_data;
        end
    end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register: packs the MEM beat, holds it with handshake, selects write-back data.
module mem_wb_pipe_reg
    import mem_wb_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_AW = 2,
    parameter bit          SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wb_en,
    input  logic              in_mem_r_en,
    input  logic [DATA_W-1:0] in_ld_data,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [REG_AW-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wb_en,
    output logic [REG_AW-1:0] out_dest,
    output logic [DATA_W-1:0] out_wb_data,
    output logic              fwd_valid
);

    localparam int unsigned PAYLOAD_W = payload_w(DATA_W, REG_AW);

    logic [PAYLOAD_W-1:0] in_payload, held;
    logic                 held_wb_en, held_mem_r_en;
    logic [DATA_W-1:0]    held_ld_data, held_alu_res;
    logic [REG_AW-1:0]    held_dest;

    assign in_payload = {in_wb_en, in_mem_r_en, in_ld_data, in_alu_res, in_dest};

    pipe_skid_reg #(
        .PAYLOAD_W (PAYLOAD_W),
        .SKID      (SKID)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (held)
    );

    assign {held_wb_en, held_mem_r_en, held_ld_data, held_alu_res, held_dest} = held;

    // Payload flops are not cleared by flush, so every output is qualified by out_valid.
    assign out_wb_en   = out_valid && held_wb_en;
    assign fwd_valid   = out_wb_en;
    assign out_dest    = out_valid ? held_dest : '0;
    assign out_wb_data = out_valid ? (held_mem_r_en ? held_ld_data : held_alu_res) : '0;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Lockstep bench for three builds of mem_wb_pipe_reg against a queue-based reference model.
module tb_mem_wb_pipe_reg;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  dest;
        logic        wb_en;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, in_valid, out_ready, wb_en, mem_r_en;
    logic [31:0] ld, alu;
    logic [4:0]  dest;

    logic        a_ir, a_ov, a_we, a_fv;
    logic [1:0]  a_dst;
    logic [7:0]  a_d;
    logic        b_ir, b_ov, b_we, b_fv;
    logic [1:0]  b_dst;
    logic [7:0]  b_d;
    logic        c_ir, c_ov, c_we, c_fv;
    logic [4:0]  c_dst;
    logic [31:0] c_d;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Instance 0: default skid build, 1: SKID=0, 2: DATA_W=32/REG_AW=5 skid build
    bit          skid_p [3] = '{1'b1, 1'b0, 1'b1};
    int unsigned dw_p   [3] = '{8, 8, 32};
    int unsigned aw_p   [3] = '{2, 2, 5};
    string       name_p [3] = '{"s8", "ns8", "s32"};
    beat_t       q      [3][$];

    logic        o_ir [3], o_ov [3], o_we [3], o_fv [3];
    logic [31:0] o_d  [3];
    logic [4:0]  o_dst[3];

    always #5 clk = ~clk;

    mem_wb_pipe_reg #(.DATA_W(8), .REG_AW(2), .SKID(1'b1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_ir),
        .in_wb_en(wb_en), .in_mem_r_en(mem_r_en), .in_ld_data(ld[7:0]), .in_alu_res(alu[7:0]),
        .in_dest(dest[1:0]), .out_valid(a_ov), .out_ready(out_ready), .out_wb_en(a_we),
        .out_dest(a_dst), .out_wb_data(a_d), .fwd_valid(a_fv)
    );

    mem_wb_pipe_reg #(.DATA_W(8), .REG_AW(2), .SKID(1'b0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_ir),
        .in_wb_en(wb_en), .in_mem_r_en(mem_r_en), .in_ld_data(ld[7:0]), .in_alu_res(alu[7:0]),
        .in_dest(dest[1:0]), .out_valid(b_ov), .out_ready(out_ready), .out_wb_en(b_we),
        .out_dest(b_dst), .out_wb_data(b_d), .fwd_valid(b_fv)
    );

    mem_wb_pipe_reg #(.DATA_W(32), .REG_AW(5), .SKID(1'b1)) dut_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_ir),
        .in_wb_en(wb_en), .in_mem_r_en(mem_r_en), .in_ld_data(ld), .in_alu_res(alu),
        .in_dest(dest), .out_valid(c_ov), .out_ready(out_ready), .out_wb_en(c_we),
        .out_dest(c_dst), .out_wb_data(c_d), .fwd_valid(c_fv)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mask_of(input int unsigned w);
        logic [31:0] m;
        m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return m;
    endfunction

    task automatic gather();
        o_ir[0] = a_ir; o_ov[0] = a_ov; o_we[0] = a_we; o_fv[0] = a_fv;
        o_d[0] = {24'd0, a_d}; o_dst[0] = {3'd0, a_dst};
        o_ir[1] = b_ir; o_ov[1] = b_ov; o_we[1] = b_we; o_fv[1] = b_fv;
        o_d[1] = {24'd0, b_d}; o_dst[1] = {3'd0, b_dst};
        o_ir[2] = c_ir; o_ov[2] = c_ov; o_we[2] = c_we; o_fv[2] = c_fv;
        o_d[2] = c_d; o_dst[2] = c_dst;
    endtask

    function automatic bit model_ready(input int unsigned i);
        if (skid_p[i]) return q[i].size() < 2;
        return (q[i].size() == 0) || out_ready;
    endfunction

    task automatic check_model();
        beat_t f;
        bit    v;
        gather();
        for (int unsigned i = 0; i < 3; i++) begin
            v = q[i].size() > 0;
            if (v) f = q[i][0];
            else   f = '{data: 32'd0, dest: 5'd0, wb_en: 1'b0};
            chk({name_p[i], ".in_ready"},  {31'd0, o_ir[i]}, {31'd0, model_ready(i)});
            chk({name_p[i], ".out_valid"}, {31'd0, o_ov[i]}, {31'd0, v});
            chk({name_p[i], ".out_wb_en"}, {31'd0, o_we[i]}, {31'd0, v && f.wb_en});
            chk({name_p[i], ".fwd_valid"}, {31'd0, o_fv[i]}, {31'd0, v && f.wb_en});
            chk({name_p[i], ".out_dest"},  {27'd0, o_dst[i]}, {27'd0, f.dest});
            chk({name_p[i], ".out_wb_data"}, o_d[i], f.data);
        end
    endtask

    task automatic check_reset_values();
        gather();
        for (int unsigned i = 0; i < 3; i++) begin
            chk({name_p[i], ".rst_in_ready"},  {31'd0, o_ir[i]}, 32'd1);
            chk({name_p[i], ".rst_out_valid"}, {31'd0, o_ov[i]}, 32'd0);
            chk({name_p[i], ".rst_out_wb_en"}, {31'd0, o_we[i]}, 32'd0);
            chk({name_p[i], ".rst_fwd_valid"}, {31'd0, o_fv[i]}, 32'd0);
            chk({name_p[i], ".rst_out_dest"},  {27'd0, o_dst[i]}, 32'd0);
            chk({name_p[i], ".rst_out_wb_data"}, o_d[i], 32'd0);
        end
    endtask

    // Entered at posedge+1; checks mid-cycle, advances one edge, updates the model.
    task automatic step();
        bit    acc [3];
        bit    emt [3];
        beat_t b;
        #2;
        check_model();
        for (int unsigned i = 0; i < 3; i++) begin
            acc[i] = in_valid && model_ready(i);
            emt[i] = (q[i].size() > 0) && out_ready;
        end
        @(posedge clk);
        for (int unsigned i = 0; i < 3; i++) begin
            if (flush) begin
                q[i].delete();
            end else begin
                if (emt[i]) void'(q[i].pop_front());
                if (acc[i]) begin
                    b.data  = (mem_r_en ? ld : alu) & mask_of(dw_p[i]);
                    b.dest  = dest & mask_of(aw_p[i]);
                    b.wb_en = wb_en;
                    q[i].push_back(b);
                end
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic mr, input logic [31:0] l,
                         input logic [31:0] a, input logic [4:0] d, input logic ordy,
                         input logic fl);
        in_valid = v; wb_en = we; mem_r_en = mr; ld = l; alu = a; dest = d;
        out_ready = ordy; flush = fl;
    endtask

    task automatic drive_random();
        drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), $urandom, $urandom,
              5'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        #12;
        rst = 1'b0;
        check_reset_values();
        @(posedge clk);
        #1;

        // Load selects ld_data, non-load selects alu_res
        drive(1'b1, 1'b1, 1'b1, 32'h0000_00A5, 32'h0000_003C, 5'd2, 1'b1, 1'b0);
        step();
        chk("ld_sel.data", {24'd0, a_d}, 32'h0000_00A5);
        chk("ld_sel.dest", {30'd0, a_dst}, 32'd2);
        chk("ld_sel.fwd", {31'd0, a_fv}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_00A5, 32'h0000_003C, 5'd2, 1'b1, 1'b0);
        step();
        chk("alu_sel.data", {24'd0, a_d}, 32'h0000_003C);

        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'h0000_0011, 5'd1, 1'b1, 1'b0);
        step();
        chk("no_wb.valid", {31'd0, a_ov}, 32'd1);
        chk("no_wb.wb_en", {31'd0, a_we}, 32'd0);
        chk("no_wb.fwd", {31'd0, a_fv}, 32'd0);

        // Streaming at full rate
        for (int unsigned k = 1; k <= 16; k++) begin
            drive(1'b1, 1'b1, 1'b0, 32'd0, 32'h1234_5600 + k, 5'(k), 1'b1, 1'b0);
            chk("stream.in_ready_s8", {31'd0, a_ir}, 32'd1);
            chk("stream.in_ready_s32", {31'd0, c_ir}, 32'd1);
            step();
            chk("stream.order_s8", {24'd0, a_d}, k);
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
        step();
        step();

        // Stall: two beats absorbed, third held off, then drained in order
        drive(1'b1, 1'b1, 1'b0, 32'd0, 32'h20, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'd0, 32'h21, 5'd1, 1'b0, 1'b0);
        step();
        chk("stall.in_ready", {31'd0, a_ir}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'd0, 32'h22, 5'd2, 1'b0, 1'b0);
        step();
        chk("stall.hold", {24'd0, a_d}, 32'h20);
        drive(1'b1, 1'b1, 1'b0, 32'd0, 32'h22, 5'd2, 1'b1, 1'b0);
        step();
        chk("drain.second", {24'd0, a_d}, 32'h21);
        step();
        chk("drain.third", {24'd0, a_d}, 32'h22);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
        step();
        chk("drain.empty", {31'd0, a_ov}, 32'd0);
        step();

        // Flush while in SKID state with a colliding offer
        drive(1'b1, 1'b1, 1'b0, 32'd0, 32'h30, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'd0, 32'h31, 5'd1, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'd0, 32'h40, 5'd2, 1'b0, 1'b1);
        step();
        chk("flush.valid", {31'd0, a_ov}, 32'd0);
        chk("flush.in_ready", {31'd0, a_ir}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 32'd0, 32'h55, 5'd3, 1'b1, 1'b0);
        step();
        chk("post_flush.data", {24'd0, a_d}, 32'h55);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
        step();
        chk("post_flush.no_stale", {31'd0, a_ov}, 32'd0);

        for (int unsigned k = 0; k < 400; k++) begin
            drive_random();
            step();
        end

        // Asynchronous reset in the middle of a stall
        drive(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd7, 1'b0, 1'b0);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check_reset_values();
        for (int unsigned i = 0; i < 3; i++) q[i].delete();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int unsigned k = 0; k < 100; k++) begin
            drive_random();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
